// File: rtl/rx_8250_serial_pkg.sv
// Shared types for the 8250 serial receive path: FSM state encoding and the
// parity check used when a frame completes.
package rx_8250_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Error when the ones count over data plus parity bit disagrees with the selected sense.
  function automatic logic parity_error(input logic       en,
                                        input logic [7:0] data,
                                        input logic       pbit,
                                        input logic       odd);
    return en & (^data ^ pbit ^ odd);
  endfunction

endpackage

// File: rtl/rx_8250_serial_baud_tick_gen.sv
// Divisor reload counter producing a one-clk baud tick every `divisor` clocks.
// A divisor of 0 stops the ticks; a new divisor is picked up at the next reload.
module baud_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (divisor == '0) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= divisor - DIV_W'(1);
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick = (divisor != '0) && (cnt == '0);

endmodule

// File: rtl/rx_8250_serial.sv
// Asynchronous serial receiver (start, 8 data LSB first, optional parity, 1 stop)
// with 16x oversampling; hands each byte to the 8250 control block.
module rx_8250_serial
  import rx_8250_serial_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  input  logic             sin,
  input  logic             parity_en,
  input  logic             parity_odd,
  output logic [7:0]       data_in,
  output logic             data_finish,
  output logic             parity_err,
  output logic             frame_err,
  output logic             rx_busy
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] MID_START = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] MID_BIT   = SC_W'(OVERSAMPLE - 1);

  logic            sin_meta;
  logic            s;
  logic            tick;
  logic            enabled;
  rx_state_t       state;
  logic            armed;
  logic [SC_W-1:0] sc;
  logic [2:0]      bc;
  logic [7:0]      shreg;
  logic            pbit;
  logic            pen_q;
  logic            podd_q;

  // Line idles high, so the synchronizer resets to 1 to avoid a phantom start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_meta <= 1'b1;
      s        <= 1'b1;
    end else begin
      sin_meta <= sin;
      s        <= sin_meta;
    end
  end

  baud_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .divisor (divisor),
    .tick    (tick)
  );

  assign enabled = (divisor != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      armed       <= 1'b0;
      sc          <= '0;
      bc          <= '0;
      shreg       <= '0;
      pbit        <= 1'b0;
      pen_q       <= 1'b0;
      podd_q      <= 1'b0;
      data_in     <= '0;
      data_finish <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      data_finish <= 1'b0;
      if (!enabled) begin
        state   <= ST_IDLE;
        rx_busy <= 1'b0;
      end else if (tick) begin
        sc <= sc + SC_W'(1);
        case (state)
          ST_IDLE: begin
            if (s) begin
              armed <= 1'b1;
            end else if (armed) begin
              state   <= ST_START;
              sc      <= '0;
              rx_busy <= 1'b1;
            end
          end
          ST_START: begin
            if (sc == MID_START) begin
              if (!s) begin
                state  <= ST_DATA;
                sc     <= '0;
                bc     <= '0;
                pen_q  <= parity_en;
                podd_q <= parity_odd;
              end else begin
                state   <= ST_IDLE;
                rx_busy <= 1'b0;
              end
            end
          end
          ST_DATA: begin
            if (sc == MID_BIT) begin
              shreg <= {s, shreg[7:1]};
              bc    <= bc + 3'd1;
              if (bc == 3'd7) state <= pen_q ? ST_PARITY : ST_STOP;
            end
          end
          ST_PARITY: begin
            if (sc == MID_BIT) begin
              pbit  <= s;
              state <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (sc == MID_BIT) begin
              data_in     <= shreg;
              frame_err   <= ~s;
              parity_err  <= parity_error(pen_q, shreg, pbit, podd_q);
              data_finish <= 1'b1;
              state       <= ST_IDLE;
              rx_busy     <= 1'b0;
              // A low stop bit may be a break; wait for the line to go high before rearming.
              armed       <= s;
            end
          end
          default: begin
            state   <= ST_IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_8250_serial.sv
// Directed bench for rx_8250_serial: a table of framed bytes plus hand-written
// sequences for glitch, break, reset-abort and back-to-back frames.
module tb_rx_8250_serial;

  localparam int BIT = 64;  // divisor 4 x 16 ticks per bit

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] divisor;
  logic        sin;
  logic        parity_en;
  logic        parity_odd;
  logic [7:0]  data_in;
  logic        data_finish;
  logic        parity_err;
  logic        frame_err;
  logic        rx_busy;

  rx_8250_serial dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .divisor     (divisor),
    .sin         (sin),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .data_in     (data_in),
    .data_finish (data_finish),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[9];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fin_cnt = 0;
  int   wide_cnt = 0;
  logic prev_fin = 1'b0;
  logic busy_seen = 1'b0;
  logic [7:0] fin_data[64];
  int   fin_cyc[64];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_finish) begin
      if (fin_cnt < 64) begin
        fin_data[fin_cnt] = data_in;
        fin_cyc[fin_cnt]  = cyc;
      end
      fin_cnt++;
      if (prev_fin) wide_cnt++;
    end
    prev_fin = data_finish;
    if (rx_busy) busy_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic line(input logic v, input int n);
    sin = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pb, input logic stop);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(d[i], BIT);
    if (pen) line(pb, BIT);
    line(stop, BIT);
  endtask

  initial begin
    int n0;
    int st;
    int lat;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};
    vecs[8] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};

    rst_n = 1'b0; sin = 1'b1; divisor = 16'd4; parity_en = 1'b0; parity_odd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset data_in", 32'(data_in), 32'h00);
    chk("reset data_finish", 32'(data_finish), 0);
    chk("reset parity_err", 32'(parity_err), 0);
    chk("reset frame_err", 32'(frame_err), 0);
    chk("reset rx_busy", 32'(rx_busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    line(1'b1, 3 * BIT);

    for (int i = 0; i < 9; i++) begin
      parity_en  = vecs[i].pen;
      parity_odd = vecs[i].podd;
      n0 = fin_cnt;
      st = cyc;
      send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop);
      line(1'b1, 2 * BIT);
      $display("vec %0d: sent %02h pen=%0b odd=%0b p=%0b stop=%0b", i, vecs[i].data,
               vecs[i].pen, vecs[i].podd, vecs[i].pbit, vecs[i].stop);
      chk($sformatf("vec%0d finish count", i), 32'(fin_cnt - n0), 1);
      chk($sformatf("vec%0d data_in", i), 32'(data_in), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d parity_err", i), 32'(parity_err), 32'(vecs[i].exp_perr));
      chk($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      if (i == 0 && fin_cnt > n0 && n0 < 64) begin
        lat = fin_cyc[n0] - st;
        checks++;
        if (lat < 610 || lat > 615) begin
          errors++;
          $display("FAIL latency: got %0d clk expected 610..615", lat);
        end else begin
          $display("ok   latency: %0d clk", lat);
        end
      end
    end

    // Short low glitch on an idle line must abort in START.
    parity_en = 1'b0;
    busy_seen = 1'b0;
    n0 = fin_cnt;
    line(1'b0, 12);
    line(1'b1, 200);
    chk("glitch busy pulse", 32'(busy_seen), 1);
    chk("glitch busy idle", 32'(rx_busy), 0);
    chk("glitch no finish", 32'(fin_cnt - n0), 0);

    // Break: stop bit low and line held low; no rearm until it goes high.
    n0 = fin_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    line(1'b0, 30 * BIT);
    chk("break finish count", 32'(fin_cnt - n0), 1);
    chk("break data_in", 32'(data_in), 32'h55);
    chk("break frame_err", 32'(frame_err), 1);
    line(1'b1, 2 * BIT);
    n0 = fin_cnt;
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    line(1'b1, 2 * BIT);
    chk("after break count", 32'(fin_cnt - n0), 1);
    chk("after break data_in", 32'(data_in), 32'h12);
    chk("after break frame_err", 32'(frame_err), 0);

    // Reset during data bit 4 of 0xFF.
    n0 = fin_cnt;
    line(1'b0, BIT);
    for (int i = 0; i < 4; i++) line(1'b1, BIT);
    line(1'b1, 20);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset data_in", 32'(data_in), 0);
    chk("midreset rx_busy", 32'(rx_busy), 0);
    chk("midreset data_finish", 32'(data_finish), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    line(1'b1, 10 * BIT);
    chk("aborted frame no finish", 32'(fin_cnt - n0), 0);
    n0 = fin_cnt;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    line(1'b1, 2 * BIT);
    chk("post reset count", 32'(fin_cnt - n0), 1);
    chk("post reset data_in", 32'(data_in), 32'h81);

    // Back-to-back frames with no idle gap.
    n0 = fin_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    line(1'b1, 2 * BIT);
    chk("b2b count", 32'(fin_cnt - n0), 2);
    if (fin_cnt - n0 == 2 && n0 + 1 < 64) begin
      chk("b2b first", 32'(fin_data[n0]), 32'h00);
      chk("b2b second", 32'(fin_data[n0 + 1]), 32'hFF);
      chk("b2b spacing", 32'(fin_cyc[n0 + 1] - fin_cyc[n0]), 640);
    end

    chk("finish pulse width", 32'(wide_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
